// File: rtl/bcd_adder_core.sv
// Registered single-digit BCD adder slice: raw binary sum plus decimal-corrected digit.
// Optional input validation is built when BCD_INPUT_CHECK_EN is defined; otherwise err is tied low.
module bcd_adder_core (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic       out_valid,
  output logic [3:0] Sum,
  output logic       Cout,
  output logic [3:0] Sum2,
  output logic       Cout2,
  output logic       err
);

  logic [4:0] w_raw;
  logic       w_fix;
  logic [3:0] w_sum2;

  logic       r_out_valid;
  logic [3:0] r_sum;
  logic       r_cout;
  logic [3:0] r_sum2;
  logic       r_cout2;

  // Correction threshold is "raw value above 9"; codes 10..15 inside the low
  // nibble are caught by the Sum[3]&(Sum[2]|Sum[1]) term.
  always_comb begin
    // NOTE: every always_comb output is assigned a default first so no path
    // through the block can leave it unassigned and infer a latch.
    w_raw  = 5'd0;
    w_fix  = 1'b0;
    w_sum2 = 4'd0;
    w_raw  = {1'b0, A} + {1'b0, B} + {4'd0, Cin};
    w_fix  = w_raw[4] | (w_raw[3] & (w_raw[2] | w_raw[1]));
    w_sum2 = w_fix ? (w_raw[3:0] + 4'd6) : w_raw[3:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_sum       <= 4'd0;
      r_cout      <= 1'b0;
      r_sum2      <= 4'd0;
      r_cout2     <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_sum   <= w_raw[3:0];
        r_cout  <= w_raw[4];
        r_sum2  <= w_sum2;
        r_cout2 <= w_fix;
      end
    end
  end

`ifdef BCD_INPUT_CHECK_EN
  logic r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (in_valid) begin
      r_err <= (A > 4'd9) || (B > 4'd9);
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign out_valid = r_out_valid;
  assign Sum       = r_sum;
  assign Cout      = r_cout;
  assign Sum2      = r_sum2;
  assign Cout2     = r_cout2;

endmodule

// File: tb/tb_bcd_adder_core.sv
// Table-driven bench for bcd_adder_core: back-to-back vectors, stall, mid-stream reset.
module tb_bcd_adder_core;

`ifdef BCD_INPUT_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] A, B;
  logic       Cin;
  logic       out_valid;
  logic [3:0] Sum, Sum2;
  logic       Cout, Cout2, err;

  int n_cmp = 0;
  int n_bad = 0;

  bcd_adder_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .out_valid (out_valid),
    .Sum       (Sum),
    .Cout      (Cout),
    .Sum2      (Sum2),
    .Cout2     (Cout2),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] sum;
    logic       cout;
    logic [3:0] sum2;
    logic       cout2;
    logic       bad_in;
  } vec_t;

  // Packed view: {out_valid, Cout, Sum, Cout2, Sum2, err}
  function automatic logic [11:0] pack(input logic v, input logic c, input logic [3:0] s,
                                       input logic c2, input logic [3:0] s2, input logic e);
    return {v, c, s, c2, s2, e};
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got v,c,sum,c2,sum2,err=%b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b, input logic c);
    @(negedge clk);
    in_valid = v;
    A        = a;
    B        = b;
    Cin      = c;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    logic [11:0] hold;

    vecs.push_back('{4'd2,  4'd3, 1'b0, 4'b0101, 1'b0, 4'b0101, 1'b0, 1'b0});
    vecs.push_back('{4'd4,  4'd5, 1'b0, 4'b1001, 1'b0, 4'b1001, 1'b0, 1'b0});
    vecs.push_back('{4'd6,  4'd7, 1'b0, 4'b1101, 1'b0, 4'b0011, 1'b1, 1'b0});
    vecs.push_back('{4'd5,  4'd8, 1'b0, 4'b1101, 1'b0, 4'b0011, 1'b1, 1'b0});
    vecs.push_back('{4'd9,  4'd1, 1'b0, 4'b1010, 1'b0, 4'b0000, 1'b1, 1'b0});
    vecs.push_back('{4'd9,  4'd9, 1'b0, 4'b0010, 1'b1, 4'b1000, 1'b1, 1'b0});
    vecs.push_back('{4'd9,  4'd9, 1'b1, 4'b0011, 1'b1, 4'b1001, 1'b1, 1'b0});
    vecs.push_back('{4'd0,  4'd0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0});
    vecs.push_back('{4'd0,  4'd0, 1'b1, 4'b0001, 1'b0, 4'b0001, 1'b0, 1'b0});
    vecs.push_back('{4'd8,  4'd1, 1'b0, 4'b1001, 1'b0, 4'b1001, 1'b0, 1'b0});
    vecs.push_back('{4'd9,  4'd0, 1'b1, 4'b1010, 1'b0, 4'b0000, 1'b1, 1'b0});
    vecs.push_back('{4'd7,  4'd3, 1'b0, 4'b1010, 1'b0, 4'b0000, 1'b1, 1'b0});
    vecs.push_back('{4'd12, 4'd1, 1'b0, 4'b1101, 1'b0, 4'b0011, 1'b1, 1'b1});
    vecs.push_back('{4'd3,  4'd4, 1'b0, 4'b0111, 1'b0, 4'b0111, 1'b0, 1'b0});
    vecs.push_back('{4'd15, 4'd15, 1'b1, 4'b1111, 1'b1, 4'b0101, 1'b1, 1'b1});
    vecs.push_back('{4'd10, 4'd0, 1'b0, 4'b1010, 1'b0, 4'b0000, 1'b1, 1'b1});
    vecs.push_back('{4'd2,  4'd14, 1'b0, 4'b0000, 1'b1, 4'b0110, 1'b1, 1'b1});

    rst_n    = 1'b0;
    in_valid = 1'b0;
    A        = 4'd0;
    B        = 4'd0;
    Cin      = 1'b0;
    #12;
    check("reset_state", pack(out_valid, Cout, Sum, Cout2, Sum2, err), 12'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back: one accepted input per cycle.
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].cin);
      check($sformatf("vec%0d_%0d+%0d+%0d", i, vecs[i].a, vecs[i].b, vecs[i].cin),
            pack(out_valid, Cout, Sum, Cout2, Sum2, err),
            pack(1'b1, vecs[i].cout, vecs[i].sum, vecs[i].cout2, vecs[i].sum2,
                 vecs[i].bad_in & CHECK_EN));
    end

    // Stall: outputs hold while out_valid drops, even as A/B/Cin wiggle.
    drive(1'b1, 4'd6, 4'd7, 1'b0);
    check("stall_pre", pack(out_valid, Cout, Sum, Cout2, Sum2, err),
          pack(1'b1, 1'b0, 4'b1101, 1'b1, 4'b0011, 1'b0));
    hold = pack(1'b0, 1'b0, 4'b1101, 1'b1, 4'b0011, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 4'(k + 1), 4'd9, 1'b1);
      check($sformatf("stall_%0d", k), pack(out_valid, Cout, Sum, Cout2, Sum2, err), hold);
    end

    // Error flag must hold during a stall too.
    drive(1'b1, 4'd11, 4'd2, 1'b0);
    drive(1'b0, 4'd1, 4'd1, 1'b0);
    check("err_hold", pack(out_valid, Cout, Sum, Cout2, Sum2, err),
          pack(1'b0, 1'b0, 4'b1101, 1'b1, 4'b0011, CHECK_EN));

    // Mid-stream asynchronous reset between edges.
    drive(1'b1, 4'd9, 4'd9, 1'b1);
    check("pre_reset", pack(out_valid, Cout, Sum, Cout2, Sum2, err),
          pack(1'b1, 1'b1, 4'b0011, 1'b1, 4'b1001, 1'b0));
    @(negedge clk);
    in_valid = 1'b1;
    A        = 4'd8;
    B        = 4'd8;
    Cin      = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", pack(out_valid, Cout, Sum, Cout2, Sum2, err), 12'd0);
    @(posedge clk);
    #1;
    check("pending_discarded", pack(out_valid, Cout, Sum, Cout2, Sum2, err), 12'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    check("idle_after_release", pack(out_valid, Cout, Sum, Cout2, Sum2, err), 12'd0);
    drive(1'b1, 4'd2, 4'd3, 1'b0);
    check("first_after_reset", pack(out_valid, Cout, Sum, Cout2, Sum2, err),
          pack(1'b1, 1'b0, 4'b0101, 1'b0, 4'b0101, 1'b0));
    drive(1'b0, 4'd0, 4'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
